// File: rtl/mprj_io_cfg_loader.sv
// I/O pad configuration loader: register file, snapshot, then shifts every pad's
// word out over NUM_CHAINS serial chains with a programmable clock divider.

module mprj_io_cfg_chain #(
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         snap_i,
  input  logic [B-1:0] snap_data_i,
  input  logic         shift_i,
  output logic         msb_o,
  output logic         nxt_msb_o
);
  logic [B-1:0] sr_q, sr_shl;

  assign sr_shl    = sr_q << 1;
  assign msb_o     = sr_q[B-1];
  assign nxt_msb_o = sr_shl[B-1];

  always_ff @(posedge clk) begin
    if (reset)        sr_q <= '0;
    else if (snap_i)  sr_q <= snap_data_i;
    else if (shift_i) sr_q <= sr_shl;
  end
endmodule

module mprj_io_cfg_loader #(
  parameter int                 NUM_PADS    = 38,
  parameter int                 NUM_CHAINS  = 2,
  parameter int                 CFG_BITS    = 13,
  parameter int                 CLK_DIV     = 2,
  parameter logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403,
  localparam int                AW          = $clog2(NUM_PADS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [CFG_BITS-1:0]   cfg_wdata,
  output logic [CFG_BITS-1:0]   cfg_rdata,
  input  logic                  start,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic                  loader_resetn,
  output logic                  loader_clock,
  output logic                  loader_load,
  output logic [NUM_CHAINS-1:0] loader_data
);
  localparam int PPC = NUM_PADS / NUM_CHAINS;
  localparam int B   = PPC * CFG_BITS;
  localparam int BCW = $clog2(B + 1);
  localparam int HCW = $clog2(2 * CLK_DIV + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT_LO, S_SHIFT_HI, S_LOAD, S_DONE} state_e;

  logic [NUM_PADS-1:0][CFG_BITS-1:0] rf_q;
  logic [CFG_BITS-1:0]   rdata_q;
  state_e                state_q;
  logic [HCW-1:0]        hc_q;
  logic [BCW-1:0]        bc_q;
  logic                  busy_q, done_q, resetn_q, lclk_q, load_q;
  logic [NUM_CHAINS-1:0] data_q;
  logic [NUM_CHAINS-1:0] snap_msb, cur_msb, nxt_msb;
  logic                  addr_ok, snap, shift;

  assign addr_ok = (32'(cfg_addr) < NUM_PADS);
  assign snap    = (state_q == S_IDLE) && start;
  assign shift   = (state_q == S_SHIFT_HI) && (hc_q == '0);

  // Chain c's snapshot is its pad slice flattened, highest pad in the MSBs.
  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
    assign snap_msb[c] = rf_q[(c+1)*PPC-1][CFG_BITS-1];
    mprj_io_cfg_chain #(.B(B)) u_chain (
      .clk         (clk),
      .reset       (reset),
      .snap_i      (snap),
      .snap_data_i (rf_q[(c+1)*PPC-1 -: PPC]),
      .shift_i     (shift),
      .msb_o       (cur_msb[c]),
      .nxt_msb_o   (nxt_msb[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q    <= {NUM_PADS{CFG_DEFAULT}};
      rdata_q <= '0;
    end else begin
      if (cfg_we && addr_ok) rf_q[cfg_addr] <= cfg_wdata;
      rdata_q <= addr_ok ? rf_q[cfg_addr] : '0;
    end
  end

  // Outputs are assigned on the transition into each state so they stay pure flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hc_q     <= '0;
      bc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resetn_q <= 1'b1;
      lclk_q   <= 1'b0;
      load_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q <= 1'b1;
          bc_q   <= BCW'(B);
          if (clear) begin
            state_q  <= S_CLEAR;
            resetn_q <= 1'b0;
            hc_q     <= HCW'(2 * CLK_DIV - 1);
          end else begin
            state_q <= S_SHIFT_LO;
            hc_q    <= HCW'(CLK_DIV - 1);
            data_q  <= snap_msb;
          end
        end
        S_CLEAR:
          if (hc_q == '0) begin
            state_q  <= S_SHIFT_LO;
            resetn_q <= 1'b1;
            hc_q     <= HCW'(CLK_DIV - 1);
            data_q   <= cur_msb;
          end else hc_q <= hc_q - HCW'(1);
        S_SHIFT_LO:
          if (hc_q == '0) begin
            state_q <= S_SHIFT_HI;
            lclk_q  <= 1'b1;
            hc_q    <= HCW'(CLK_DIV - 1);
          end else hc_q <= hc_q - HCW'(1);
        S_SHIFT_HI:
          if (hc_q == '0) begin
            lclk_q <= 1'b0;
            bc_q   <= bc_q - BCW'(1);
            hc_q   <= HCW'(CLK_DIV - 1);
            if (bc_q > BCW'(1)) begin
              state_q <= S_SHIFT_LO;
              data_q  <= nxt_msb;
            end else begin
              state_q <= S_LOAD;
              load_q  <= 1'b1;
              data_q  <= '0;
            end
          end else hc_q <= hc_q - HCW'(1);
        S_LOAD:
          if (hc_q == '0) begin
            state_q <= S_DONE;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else hc_q <= hc_q - HCW'(1);
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_rdata     = rdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign loader_resetn = resetn_q;
  assign loader_clock  = lclk_q;
  assign loader_load   = load_q;
  assign loader_data   = data_q;
endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Bench: two loaders (D=1 and D=3) on shared stimulus, checked every cycle against a
// timeline model, plus literal expectations for the directed scenarios.

module tb_mprj_io_cfg_loader;
  logic       clk = 1'b0, reset = 1'b1, cfg_we = 1'b0, start = 1'b0, clear = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [3:0] cfg_wdata = '0;
  logic [3:0] rd0, rd3;
  logic       bz0, dn0, rn0, lc0, ll0, bz3, dn3, rn3, lc3, ll3;
  logic [1:0] ld0, ld3;

  always #5 clk = ~clk;

  mprj_io_cfg_loader #(.NUM_PADS(4), .NUM_CHAINS(2), .CFG_BITS(4), .CLK_DIV(1), .CFG_DEFAULT(4'h3)) u_d1 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(rd0), .start(start), .clear(clear), .busy(bz0), .done(dn0),
    .loader_resetn(rn0), .loader_clock(lc0), .loader_load(ll0), .loader_data(ld0));

  mprj_io_cfg_loader #(.NUM_PADS(4), .NUM_CHAINS(2), .CFG_BITS(4), .CLK_DIV(3), .CFG_DEFAULT(4'h3)) u_d3 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(rd3), .start(start), .clear(clear), .busy(bz3), .done(dn3),
    .loader_resetn(rn3), .loader_clock(lc3), .loader_load(ll3), .loader_data(ld3));

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act_v, input int exp_v);
    n_cmp++;
    if (act_v != exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  // Output bundle order: resetn, clock, load, busy, done, data[1:0]
  typedef struct packed {
    logic rstn, lclk, load, busy, done;
    logic [1:0] data;
  } obs_t;

  // Expected outputs k cycles after the accepting edge, from the timing rules.
  function automatic obs_t model_out(input int d, input bit a, input int k, input bit c,
                                     input logic [1:0][7:0] s);
    obs_t o;
    int pre, j, bi;
    o = '0;
    o.rstn = 1'b1;
    if (a) begin
      o.busy = 1'b1;
      pre = c ? 2 * d : 0;
      if (k <= pre) o.rstn = 1'b0;
      else begin
        j = k - 1 - pre;
        if (j < 2 * d * 8) begin
          bi = j / (2 * d);
          o.lclk = ((j % (2 * d)) >= d);
          o.data[0] = s[0][7-bi];
          o.data[1] = s[1][7-bi];
        end else if (j < 2 * d * 8 + d) o.load = 1'b1;
        else begin
          o.busy = 1'b0;
          o.done = 1'b1;
        end
      end
    end
    return o;
  endfunction

  logic [3:0]       rfm [4];
  logic [3:0]       exp_rd;
  bit               mact [2];
  int               kk [2];
  bit               mclr [2];
  logic [1:0][7:0]  msnap [2];
  int               dv, nn;
  obs_t             e0, e3;

  always begin
    @(posedge clk);
    if (reset) begin
      for (int a = 0; a < 4; a++) rfm[a] = 4'h3;
      exp_rd = '0;
      mact[0] = 1'b0;
      mact[1] = 1'b0;
      chk_en = 1'b1;
    end else begin
      exp_rd = rfm[cfg_addr];
      for (int i = 0; i < 2; i++) begin
        dv = (i == 1) ? 3 : 1;
        nn = (mclr[i] ? 2 * dv : 0) + 17 * dv;
        if (mact[i]) begin
          if (kk[i] == nn + 1) mact[i] = 1'b0;
          else kk[i]++;
        end else if (start) begin
          mact[i] = 1'b1;
          kk[i] = 1;
          mclr[i] = clear;
          msnap[i][0] = {rfm[1], rfm[0]};
          msnap[i][1] = {rfm[3], rfm[2]};
        end
      end
      if (cfg_we) rfm[cfg_addr] = cfg_wdata;
    end
    #1;
    if (chk_en) begin
      e0 = model_out(1, mact[0], kk[0], mclr[0], msnap[0]);
      e3 = model_out(3, mact[1], kk[1], mclr[1], msnap[1]);
      chk("outs_d1", {rn0, lc0, ll0, bz0, dn0, ld0}, int'(e0));
      chk("outs_d3", {rn3, lc3, ll3, bz3, dn3, ld3}, int'(e3));
      chk("rdata_d1", rd0, exp_rd);
      chk("rdata_d3", rd3, exp_rd);
    end
  end

  // Directed-scenario observations of both instances
  int   rises0, loadcyc0, loadpul0, done0, donecnt0, rlow_first, rlow_cnt, first_rise;
  int   rises3, hi3, done3;
  logic [7:0] cap0, cap1, cap30, cap31;
  logic plc0, pll0, plc3;

  task automatic sample(input int off);
    if (lc0 && !plc0) begin
      rises0++;
      cap0 = {cap0[6:0], ld0[0]};
      cap1 = {cap1[6:0], ld0[1]};
      if (first_rise < 0) first_rise = off;
    end
    if (ll0) begin
      loadcyc0++;
      if (!pll0) loadpul0++;
    end
    if (!rn0) begin
      if (rlow_first < 0) rlow_first = off;
      rlow_cnt++;
    end
    if (dn0) begin
      donecnt0++;
      if (done0 < 0) done0 = off;
    end
    if (lc3 && !plc3) begin
      rises3++;
      cap30 = {cap30[6:0], ld3[0]};
      cap31 = {cap31[6:0], ld3[1]};
    end
    if (lc3) hi3++;
    if (dn3 && done3 < 0) done3 = off;
    plc0 = lc0;
    pll0 = ll0;
    plc3 = lc3;
  endtask

  task automatic run_seq(input bit clr, input bit poke);
    rises0 = 0; loadcyc0 = 0; loadpul0 = 0; done0 = -1; donecnt0 = 0;
    rlow_first = -1; rlow_cnt = 0; first_rise = -1;
    rises3 = 0; hi3 = 0; done3 = -1;
    cap0 = '0; cap1 = '0; cap30 = '0; cap31 = '0;
    plc0 = 1'b0; pll0 = 1'b0; plc3 = 1'b0;
    start = 1'b1;
    clear = clr;
    @(posedge clk); #2;
    start = 1'b0;
    clear = 1'b0;
    for (int off = 1; off <= 60; off++) begin
      sample(off);
      if (poke && off == 4) begin
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 4'hF; start = 1'b1;
      end else begin
        cfg_we = 1'b0; start = 1'b0;
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #2;
    cfg_we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input int exp_v);
    cfg_addr = a;
    @(posedge clk); #2;
    chk(nm, rd0, exp_v);
  endtask

  initial begin
    int r5, lp, dc;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    chk("rst_outs_d1", {rn0, lc0, ll0, bz0, dn0, ld0}, 7'b1000000);
    chk("rst_outs_d3", {rn3, lc3, ll3, bz3, dn3, ld3}, 7'b1000000);
    for (int a = 0; a < 4; a++) rd_chk("rd_default", 2'(a), 4'h3);

    wr(2'd0, 4'h1); wr(2'd1, 4'hA); wr(2'd2, 4'h3); wr(2'd3, 4'hC);

    run_seq(1'b0, 1'b0);
    chk("basic_chain0", cap0, 8'hA1);
    chk("basic_chain1", cap1, 8'hC3);
    chk("basic_rises", rises0, 8);
    chk("basic_load_pulses", loadpul0, 1);
    chk("basic_load_width", loadcyc0, 1);
    chk("basic_done_at", done0, 18);
    chk("basic_done_count", donecnt0, 1);
    chk("d3_chain0", cap30, 8'hA1);
    chk("d3_chain1", cap31, 8'hC3);
    chk("d3_rises", rises3, 8);
    chk("d3_high_cycles", hi3, 24);
    chk("d3_done_at", done3, 52);

    run_seq(1'b1, 1'b0);
    chk("clr_resetn_first", rlow_first, 1);
    chk("clr_resetn_len", rlow_cnt, 2);
    chk("clr_first_rise", first_rise, 4);
    chk("clr_done_at", done0, 20);
    chk("clr_chain0", cap0, 8'hA1);

    run_seq(1'b0, 1'b1);
    chk("snap_chain0", cap0, 8'hA1);
    chk("snap_chain1", cap1, 8'hC3);
    chk("snap_done_count", donecnt0, 1);
    rd_chk("snap_pad3_rd", 2'd3, 4'hF);

    // Reset sampled right after the 5th serial clock rise
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    r5 = 0;
    plc0 = 1'b0;
    for (int off = 1; off <= 40; off++) begin
      if (lc0 && !plc0) r5++;
      plc0 = lc0;
      if (r5 == 5) break;
      @(posedge clk); #2;
    end
    chk("midrst_rise5", r5, 5);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("midrst_idle_d1", {rn0, lc0, ll0, bz0, dn0, ld0}, 7'b1000000);
    chk("midrst_idle_d3", {rn3, lc3, ll3, bz3, dn3, ld3}, 7'b1000000);
    lp = 0; dc = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (ll0) lp++;
      if (dn0) dc++;
    end
    chk("midrst_no_load", lp, 0);
    chk("midrst_no_done", dc, 0);
    for (int a = 0; a < 4; a++) rd_chk("midrst_rd_default", 2'(a), 4'h3);

    // Randomised traffic; the per-cycle model does the checking
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 499) == 0);
      cfg_we    = ($urandom_range(0, 2) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = 4'($urandom);
      start     = ($urandom_range(0, 24) == 0);
      clear     = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    reset = 1'b0; cfg_we = 1'b0; start = 1'b0; clear = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
